led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
Controller that sequences the board's LED timer datapath. It synchronises the slide switches and start/stop buttons, runs a programmable prescaler that produces the LED step tick, and steps an LED pattern register through one of four animation modes under a small run/pause state machine. Sits between board I/O (switches, buttons) and the LED bank in the top level, in the same mclk domain as the LED timer.

Parameters:
W, 8, LED bank width (>=4)
DIV_BASE, 50000000, mclk cycles per tick at speed 0
CW, 32, prescaler counter width; must hold DIV_BASE*8-1

Ports:
mclk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
swt  in  2  pattern mode select, asynchronous
spd  in  2  speed select, tick period = DIV_BASE<<spd cycles, asynchronous
btn_start  in  1  start/resume button, asynchronous, active-high
btn_stop  in  1  pause/clear button, asynchronous, active-high
led  out  W  LED pattern
tick  out  1  one-cycle pulse per pattern step
busy  out  1  high when state != IDLE
state  out  2  current FSM state (debug)

Behaviour:
- Reset (rst_n low, async): led=0, tick=0, busy=0, state=IDLE, prescaler=0, dir=left, sync flops=0, latched mode/speed=0.
- All asynchronous inputs pass through 2-FF synchronisers; buttons then rising-edge detected into 1-cycle pulses start_p/stop_p. Pin high sampled at edge N -> pulse active cycle after edge N+2 -> state updates at edge N+3.
- Level held high produces exactly one pulse; must return low before another.
- FSM states: IDLE=0, RUN=1, PAUSE=2 (3 unused, recovers to IDLE).
  - IDLE: start_p -> RUN; latch mode=swt_s, speed=spd_s; load seed; prescaler=0.
  - RUN: stop_p -> PAUSE; else on each tick advance pattern.
  - PAUSE: start_p -> RUN (resume; prescaler and led unchanged); stop_p -> IDLE (led=0, prescaler=0, dir=left).
  - start_p and stop_p same cycle: stop wins in every state.
- Prescaler: counts only in RUN; held in PAUSE; cleared in IDLE. At count == (DIV_BASE<<speed)-1, tick=1 for that cycle and count wraps to 0. First tick occurs DIV_BASE<<speed cycles after entering RUN from IDLE.
- On tick edge: if swt_s != latched mode, latch new mode, load its seed (no advance), dir=left; else advance. spd_s is latched into speed at every tick; new period starts from the next count.
- Patterns (led register, updated on edge where tick=1):
  - 00 rotate-left, seed 1: led = {led[W-2:0],led[W-1]}.
  - 01 rotate-right, seed 1<<(W-1).
  - 10 bounce, seed 1: shift in dir; at led[W-1] set dir=right, at led[0] set dir=left, reversal happens on the same step as reaching the end (sequence 1,2,..,2^(W-1),2^(W-2),..,1,2..).
  - 11 binary up-count, seed 0, wraps 2^W-1 -> 0.
- led holds value in PAUSE; led=0 in IDLE.
- tick is never asserted outside RUN; a stop_p coinciding with terminal count suppresses tick and the advance.
- busy = (state != IDLE), combinational from state register.
- Reset mid-RUN returns everything to reset values immediately; no pulse generated on release.

Decomposition:
- Package led_pkg: state encodings (ST_IDLE/ST_RUN/ST_PAUSE), mode codes (MODE_ROL/MODE_ROR/MODE_BNC/MODE_CNT), seed function per mode and W.
- One sub-module: led_prescaler (CW counter, enable/clear/hold, DIV_BASE<<speed terminal, tick out). Synchronisers/edge detect inline.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> led=0, tick=0, busy=0, state=0 immediately, before next mclk edge.
- W=8, DIV_BASE=4, spd=0, swt=00, pulse btn_start -> state=RUN 3 edges later, tick every 4 cycles, led 0x01,0x02,..,0x80,0x01.
- swt=10 bounce run 16 ticks -> led 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,04.
- swt=11, spd=2 -> tick period 16 cycles, led counts 00..FF then 00; change spd to 0 mid-run -> period 4 from the tick after the change.
- RUN, pulse btn_stop -> PAUSE, led frozen, no tick for 50 cycles; btn_start -> resumes, next tick after remaining prescaler count; btn_stop twice -> IDLE, led=0, busy=0.
- btn_start and btn_stop rising on same edge while IDLE -> stays IDLE; while RUN -> PAUSE; swt changed 00->01 in RUN -> next tick loads 0x80.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state/mode encodings and pattern seeds for the LED sequencer
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_ROL = 2'd0,
        MODE_ROR = 2'd1,
        MODE_BNC = 2'd2,
        MODE_CNT = 2'd3
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Starting LED image for a mode; caller truncates to its bank width w.
    function automatic logic [63:0] mode_seed(input mode_e mode, input int unsigned w);
        case (mode)
            MODE_ROR: mode_seed = 64'd1 << (w - 32'd1);
            MODE_CNT: mode_seed = 64'd0;
            default:  mode_seed = 64'd1;
        endcase
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - step-tick prescaler with run/hold/clear control
//
// Ports:
//   mclk, rst_n : clock, asynchronous active-low reset
//   en          : count this cycle (RUN and not being stopped)
//   clr         : force count to zero (takes priority over en)
//   speed       : period select, period = DIV_BASE << speed cycles
//   tick        : high for the cycle in which the count sits at its terminal value
module led_prescaler #(
    parameter int DIV_BASE = 50000000,
    parameter int CW       = 32
) (
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] speed,
    output logic       tick
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] term;

    assign term = (CW'(DIV_BASE) << speed) - CW'(1);
    assign tick = en & ~clr & (cnt_q == term);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - run/pause LED pattern sequencer with synchronised board inputs
//
// Ports:
//   mclk, rst_n          : clock, asynchronous active-low reset
//   swt[1:0]             : pattern mode select (async)
//   spd[1:0]             : speed select, tick period DIV_BASE << spd (async)
//   btn_start, btn_stop  : start/resume and pause/clear buttons (async, active-high)
//   led[W-1:0]           : LED pattern
//   tick                 : one-cycle pulse per pattern step
//   busy                 : state != IDLE
//   state[1:0]           : current FSM state
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int W        = 8,
    parameter int DIV_BASE = 50000000,
    parameter int CW       = 32
) (
    input  logic         mclk,
    input  logic         rst_n,
    input  logic [1:0]   swt,
    input  logic [1:0]   spd,
    input  logic         btn_start,
    input  logic         btn_stop,
    output logic [W-1:0] led,
    output logic         tick,
    output logic         busy,
    output logic [1:0]   state
);

    // Input synchronisers: {swt, spd, btn_start, btn_stop} as one bundle.
    logic [5:0] in_m_q, in_m_d;
    logic [5:0] in_s_q, in_s_d;
    logic [1:0] btn_h_q, btn_h_d;   // previous synchronised button levels
    logic [1:0] btn_p_q, btn_p_d;   // registered rising-edge pulses {start, stop}

    logic [1:0] swt_s;
    logic [1:0] spd_s;
    logic       start_p;
    logic       stop_p;

    always_comb begin
        in_m_d  = {swt, spd, btn_start, btn_stop};
        in_s_d  = in_m_q;
        btn_h_d = in_s_q[1:0];
        btn_p_d = in_s_q[1:0] & ~btn_h_q;
    end

    assign swt_s   = in_s_q[5:4];
    assign spd_s   = in_s_q[3:2];
    assign start_p = btn_p_q[1];
    assign stop_p  = btn_p_q[0];

    // Sequencer state.
    state_e       state_q, state_d;
    logic [W-1:0] led_q, led_d;
    logic         dir_q, dir_d;
    mode_e        mode_q, mode_d;
    logic [1:0]   speed_q, speed_d;

    logic         pre_en;
    logic         pre_clr;
    logic         tick_w;

    // Stop wins over everything, so a stop pulse in RUN freezes the count and
    // swallows a tick that would otherwise land on the same cycle.
    assign pre_en  = (state_q == ST_RUN) & ~stop_p;
    assign pre_clr = ((state_q != ST_RUN) && (state_q != ST_PAUSE)) ||
                     ((state_q == ST_PAUSE) && stop_p);

    led_prescaler #(
        .DIV_BASE (DIV_BASE),
        .CW       (CW)
    ) u_prescaler (
        .mclk  (mclk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (pre_clr),
        .speed (speed_q),
        .tick  (tick_w)
    );

    // Next pattern image for the latched mode.
    logic [W-1:0] adv_led;
    logic         adv_dir;

    always_comb begin
        adv_led = led_q;
        adv_dir = dir_q;
        case (mode_q)
            MODE_ROL: adv_led = {led_q[W-2:0], led_q[W-1]};
            MODE_ROR: adv_led = {led_q[0], led_q[W-1:1]};
            MODE_BNC: begin
                // Direction flips on the same step that reaches an end bit.
                if (dir_q == DIR_LEFT) begin
                    adv_led = led_q << 1;
                    if (adv_led[W-1]) adv_dir = DIR_RIGHT;
                end else begin
                    adv_led = led_q >> 1;
                    if (adv_led[0]) adv_dir = DIR_LEFT;
                end
            end
            default:  adv_led = led_q + W'(1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        speed_d = speed_q;
        case (state_q)
            ST_IDLE: begin
                led_d = '0;
                dir_d = DIR_LEFT;
                if (start_p && !stop_p) begin
                    state_d = ST_RUN;
                    mode_d  = mode_e'(swt_s);
                    speed_d = spd_s;
                    led_d   = W'(mode_seed(mode_e'(swt_s), W));
                end
            end
            ST_RUN: begin
                if (stop_p) begin
                    state_d = ST_PAUSE;
                end else if (tick_w) begin
                    speed_d = spd_s;
                    if (swt_s != mode_q) begin
                        // Mode switch replaces the step with the new seed.
                        mode_d = mode_e'(swt_s);
                        led_d  = W'(mode_seed(mode_e'(swt_s), W));
                        dir_d  = DIR_LEFT;
                    end else begin
                        led_d = adv_led;
                        dir_d = adv_dir;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop_p) begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                    dir_d   = DIR_LEFT;
                end else if (start_p) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                led_d   = '0;
                dir_d   = DIR_LEFT;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            in_m_q  <= '0;
            in_s_q  <= '0;
            btn_h_q <= '0;
            btn_p_q <= '0;
            state_q <= ST_IDLE;
            led_q   <= '0;
            dir_q   <= DIR_LEFT;
            mode_q  <= MODE_ROL;
            speed_q <= '0;
        end else begin
            in_m_q  <= in_m_d;
            in_s_q  <= in_s_d;
            btn_h_q <= btn_h_d;
            btn_p_q <= btn_p_d;
            state_q <= state_d;
            led_q   <= led_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            speed_q <= speed_d;
        end
    end

    assign led   = led_q;
    assign tick  = tick_w;
    assign busy  = (state_q != ST_IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - scoreboard testbench for led_seq_ctrl
module tb_led_seq_ctrl;

    localparam int W   = 8;
    localparam int DIV = 4;
    localparam int CW  = 8;

    logic         mclk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   swt = 2'd0;
    logic [1:0]   spd = 2'd0;
    logic         btn_start = 1'b0;
    logic         btn_stop = 1'b0;
    logic [W-1:0] led;
    logic         tick;
    logic         busy;
    logic [1:0]   state;

    led_seq_ctrl #(.W(W), .DIV_BASE(DIV), .CW(CW)) dut (
        .mclk      (mclk),
        .rst_n     (rst_n),
        .swt       (swt),
        .spd       (spd),
        .btn_start (btn_start),
        .btn_stop  (btn_stop),
        .led       (led),
        .tick      (tick),
        .busy      (busy),
        .state     (state)
    );

    always #5 mclk = ~mclk;

    int cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [7:0] led;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: pattern is a pure function of (mode, step index);
    // timing is tracked as the edge number of the next expected tick.
    int m_mode, m_idx, m_per, m_next, m_last, m_rem;

    function automatic logic [7:0] pat(int mode, int idx);
        int p;
        case (mode)
            0: return 8'(1 << (idx % 8));
            1: return 8'(128 >> (idx % 8));
            2: begin
                p = idx % 14;
                if (p >= 8) p = 14 - p;
                return 8'(1 << p);
            end
            default: return 8'(idx % 256);
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every tick pops one expectation; led is compared one cycle later.
    logic       pend = 1'b0;
    logic [7:0] pend_led;
    exp_t       mon_e;

    always @(negedge mclk) begin
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                check("led_after_tick", led, pend_led);
                pend = 1'b0;
            end
            if (tick) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tick: tick=1 at cycle %0d, required 0", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("tick_cycle", cyc, mon_e.t);
                    pend     = 1'b1;
                    pend_led = mon_e.led;
                end
            end
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) @(negedge mclk);
    endtask

    // Drives the buttons; n = edge that first samples them. Returns at edge n+3.
    task automatic press(logic s, logic p, output int n);
        @(negedge mclk);
        n = cyc + 1;
        btn_start = s;
        btn_stop  = p;
        repeat (3) @(negedge mclk);
        btn_start = 1'b0;
        btn_stop  = 1'b0;
        @(negedge mclk);
    endtask

    task automatic model_tick();
        int t;
        t = m_next;
        if (int'(swt) != m_mode) begin
            m_mode = int'(swt);
            m_idx  = 0;
        end else begin
            m_idx++;
        end
        m_per  = DIV << spd;
        m_next = t + m_per;
        m_last = t;
        sb.push_back('{t, pat(m_mode, m_idx)});
    endtask

    task automatic start_from_idle();
        int n;
        press(1'b1, 1'b0, n);
        m_mode = int'(swt);
        m_idx  = 0;
        m_per  = DIV << spd;
        m_next = n + 3 + m_per - 1;
        m_last = -1;
        check("start_state", state, 2'd1);
        check("start_busy", busy, 1'b1);
        check("start_seed", led, pat(m_mode, 0));
    endtask

    task automatic run_ticks(int k, bit rnd);
        for (int i = 0; i < k; i++) begin
            while (cyc < m_last + 1) @(negedge mclk);
            if (rnd && (m_next - cyc >= 3)) begin
                if ($urandom_range(0, 3) == 0) swt = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) spd = 2'($urandom_range(0, 3));
            end
            model_tick();
            while (cyc < m_last + 1) @(negedge mclk);
        end
    endtask

    // Pause from RUN; exact=1 lands the stop pulse on the terminal-count cycle.
    task automatic pause_run(int extra, bit exact, bit both);
        int n, n_pred;
        if (exact) begin
            while (m_next - cyc - 4 < 0) model_tick();
            extra = m_next - cyc - 4;
        end
        n_pred = cyc + extra + 2;
        while (m_next <= n_pred + 1) model_tick();
        wait_cyc(extra);
        press(1'b1 & both, 1'b1, n);
        check("pause_edge", n, n_pred);
        m_rem = m_next - (n + 2);
        check("pause_state", state, 2'd2);
        wait_cyc(50);
        check("pause_led_frozen", led, pat(m_mode, m_idx));
        check("pause_busy", busy, 1'b1);
    endtask

    task automatic resume_run();
        int n, n_pred;
        n_pred = cyc + 2;
        m_next = n_pred + 3 + m_rem;
        model_tick();
        press(1'b1, 1'b0, n);
        check("resume_state", state, 2'd1);
    endtask

    task automatic stop_to_idle();
        int n;
        press(1'b0, 1'b1, n);
        check("idle_state", state, 2'd0);
        check("idle_led", led, 8'd0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int n;

        // Reset values.
        wait_cyc(3);
        check("rst_led", led, 8'd0);
        check("rst_tick", tick, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state, 2'd0);
        rst_n = 1'b1;
        wait_cyc(3);

        // Rotate-left with pause, exact-terminal stop, resume, double stop.
        swt = 2'd0; spd = 2'd0;
        wait_cyc(4);
        start_from_idle();
        run_ticks(9, 1'b0);
        pause_run(1, 1'b0, 1'b0);
        resume_run();
        run_ticks(3, 1'b0);
        pause_run(0, 1'b1, 1'b0);
        resume_run();
        run_ticks(2, 1'b0);
        pause_run(0, 1'b0, 1'b0);
        stop_to_idle();

        // Bounce, 16 steps.
        swt = 2'd2;
        wait_cyc(4);
        start_from_idle();
        run_ticks(16, 1'b0);
        pause_run(0, 1'b0, 1'b0);
        stop_to_idle();

        // Binary count at speed 2, dropping to speed 0 mid-run, through the wrap.
        swt = 2'd3; spd = 2'd2;
        wait_cyc(4);
        start_from_idle();
        run_ticks(5, 1'b0);
        spd = 2'd0;
        run_ticks(252, 1'b0);
        pause_run(0, 1'b0, 1'b0);
        stop_to_idle();

        // Start and stop together while IDLE: stays IDLE.
        press(1'b1, 1'b1, n);
        wait_cyc(3);
        check("both_idle_state", state, 2'd0);
        check("both_idle_busy", busy, 1'b0);

        // Mode change 00 -> 01 in RUN, then start+stop together while RUN.
        swt = 2'd0; spd = 2'd1;
        wait_cyc(4);
        start_from_idle();
        run_ticks(2, 1'b0);
        swt = 2'd1;
        run_ticks(3, 1'b0);
        pause_run(2, 1'b0, 1'b1);
        stop_to_idle();

        // Randomised sessions.
        for (int s = 0; s < 6; s++) begin
            swt = 2'($urandom_range(0, 3));
            spd = 2'($urandom_range(0, 3));
            wait_cyc(4);
            start_from_idle();
            run_ticks($urandom_range(3, 10), 1'b1);
            pause_run($urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            resume_run();
            run_ticks($urandom_range(1, 6), 1'b1);
            pause_run($urandom_range(0, 10), 1'b0, 1'b0);
            stop_to_idle();
        end

        // Asynchronous reset mid-RUN.
        swt = 2'd0; spd = 2'd1;
        wait_cyc(4);
        start_from_idle();
        run_ticks(3, 1'b0);
        @(posedge mclk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_led", led, 8'd0);
        check("midrst_tick", tick, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_state", state, 2'd0);
        sb.delete();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(8);
        check("post_rst_state", state, 2'd0);
        check("post_rst_led", led, 8'd0);

        wait_cyc(20);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
